// File: rtl/clk_divider_one_pkg.sv
// Shared clock helpers: default system clock rate and the minimum counter
// width needed to count through a given divide value.
package clk_divider_one_pkg;

  localparam int unsigned SYS_CLK_HZ = 100_000_000;

  // Smallest width w such that 2^w >= n (at least 1 bit).
  function automatic int min_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/clk_divider_one.sv
// Integer clock divider: 50 % duty output with period 2*FREQUENCY_DIV_HALF,
// first rising output on the first clk edge after reset release.
module clk_divider_one
  import clk_divider_one_pkg::*;
#(
  parameter int FREQUENCY_DIV_HALF           = 4,
  parameter int FREQUENCY_DIV_HALF_BIT_WIDTH = 2
) (
  input  logic clk,
  input  logic reset,
  output logic clk_div
);

  localparam int W = FREQUENCY_DIV_HALF_BIT_WIDTH;

  generate
    if (FREQUENCY_DIV_HALF < 1) begin : g_bad_div
      $error("clk_divider_one: FREQUENCY_DIV_HALF must be >= 1");
    end
    if (W < min_width(FREQUENCY_DIV_HALF)) begin : g_bad_width
      $error("clk_divider_one: counter width too small for FREQUENCY_DIV_HALF");
    end
  endgenerate

  // Explicit terminal count so non-power-of-two divides never rely on wrap.
  localparam logic [W-1:0] LAST = W'(FREQUENCY_DIV_HALF - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

  // Toggle at the start of each half-period, so the first edge drives high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_div <= 1'b0;
    end else if (cnt == '0) begin
      clk_div <= ~clk_div;
    end
  end

endmodule

// File: tb/tb_clk_divider_one.sv
// Bench for clk_divider_one: four parameterisations share one clock; expected
// output bits are queued before each edge and compared one step after it.
module tb_clk_divider_one;

  logic clk;
  logic reset_main;
  logic reset_rest;
  logic div_n4;
  logic div_n1;
  logic div_n3;
  logic div_w4;

  int checks;
  int failures;
  int k_main;
  int k_rest;

  logic [3:0] exp_q[$];

  clk_divider_one #(.FREQUENCY_DIV_HALF(4), .FREQUENCY_DIV_HALF_BIT_WIDTH(2))
    u_n4 (.clk(clk), .reset(reset_main), .clk_div(div_n4));
  clk_divider_one #(.FREQUENCY_DIV_HALF(1), .FREQUENCY_DIV_HALF_BIT_WIDTH(1))
    u_n1 (.clk(clk), .reset(reset_rest), .clk_div(div_n1));
  clk_divider_one #(.FREQUENCY_DIV_HALF(3), .FREQUENCY_DIV_HALF_BIT_WIDTH(2))
    u_n3 (.clk(clk), .reset(reset_rest), .clk_div(div_n3));
  clk_divider_one #(.FREQUENCY_DIV_HALF(4), .FREQUENCY_DIV_HALF_BIT_WIDTH(4))
    u_w4 (.clk(clk), .reset(reset_rest), .clk_div(div_w4));

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference waveform: edge k (1-based) after release lies in a high phase
  // when the count of completed half-periods is even.
  function automatic logic exp_bit(input int k, input int n);
    if (k < 1) return 1'b0;
    return (((k - 1) / n) % 2) == 0;
  endfunction

  task automatic run_edges(input int count);
    logic [3:0] e;
    for (int i = 0; i < count; i++) begin
      k_main++;
      k_rest++;
      exp_q.push_back({exp_bit(k_main, 4), exp_bit(k_rest, 1),
                       exp_bit(k_rest, 3), exp_bit(k_rest, 4)});
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check($sformatf("n4_edge%0d", k_main), {31'd0, div_n4}, {31'd0, e[3]});
      check($sformatf("n1_edge%0d", k_rest), {31'd0, div_n1}, {31'd0, e[2]});
      check($sformatf("n3_edge%0d", k_rest), {31'd0, div_n3}, {31'd0, e[1]});
      check($sformatf("w4_edge%0d", k_rest), {31'd0, div_w4}, {31'd0, e[0]});
      check("n3_cnt_below_3", {31'd0, (u_n3.cnt < 2'd3)}, 32'd1);
    end
  endtask

  // Assert reset on the main instance between edges and verify it acts
  // without waiting for a clock edge.
  task automatic mid_run_reset();
    #1 reset_main = 1'b1;
    #1;
    check("mid_reset_clk_div", {31'd0, div_n4}, 32'd0);
    check("mid_reset_cnt", {30'd0, u_n4.cnt}, 32'd0);
    reset_main = 1'b0;
    k_main = 0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    k_main = 0;
    k_rest = 0;
    reset_main = 1'b1;
    reset_rest = 1'b1;
    #1;
    check("reset_n4_div", {31'd0, div_n4}, 32'd0);
    check("reset_n4_cnt", {30'd0, u_n4.cnt}, 32'd0);
    check("reset_n1_div", {31'd0, div_n1}, 32'd0);
    check("reset_n3_div", {31'd0, div_n3}, 32'd0);
    check("reset_w4_div", {31'd0, div_w4}, 32'd0);
    check("reset_w4_cnt", {28'd0, u_w4.cnt}, 32'd0);
    #1;
    reset_main = 1'b0;
    reset_rest = 1'b0;

    run_edges(16);
    run_edges(2);
    check("pre_reset_high", {31'd0, div_n4}, 32'd1);
    mid_run_reset();
    run_edges(16 + $urandom_range(0, 8));

    check("queue_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
